// File: rtl/seq_shift_unit_if.sv
// rtl/seq_shift_unit_if.sv - start/busy/done handshake and operand/result bundle for seq_shift_unit
interface seq_shift_unit_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             Start;
    logic [WIDTH-1:0] IN;
    logic [AMT_W-1:0] ShiftAmt;
    logic             ShiftDir;
    logic [1:0]       ShiftMode;
    logic [WIDTH-1:0] Out;
    logic             Busy;
    logic             Done;
    logic             Carry;
    logic             Zero;

    modport master (
        output Start, IN, ShiftAmt, ShiftDir, ShiftMode,
        input  Out, Busy, Done, Carry, Zero
    );

    modport slave (
        input  Start, IN, ShiftAmt, ShiftDir, ShiftMode,
        output Out, Busy, Done, Carry, Zero
    );
endinterface

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - one-bit-per-clock logical/arithmetic/rotate shifter with registered flags
// Optional carry flag: SEQ_SHIFT_CARRY_EN (undefined: Carry tied to 0, no carry register).
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic          Clk,
    input logic          Rst,
    seq_shift_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] LAST_STEP = AMT_W'(1);

    state_t           state, stateNext;
    logic [WIDTH-1:0] work, shiftVal, outReg;
    logic [AMT_W-1:0] cnt;
    logic             dirRight;
    logic [1:0]       mode;
    logic             zeroReg;
    logic             accept;

    assign accept = bus.Start && (state == IDLE || state == DONE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (bus.Start) stateNext = (bus.ShiftAmt != '0) ? SHIFT : DONE;
                else           stateNext = IDLE;
            end
            SHIFT: if (cnt == LAST_STEP) stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    // Reserved mode 11 falls through to logical; arithmetic left equals logical left.
    always_comb begin
        shiftVal = work;
        if (dirRight) begin
            case (mode)
                2'b01:   shiftVal = {work[WIDTH-1], work[WIDTH-1:1]};
                2'b10:   shiftVal = {work[0], work[WIDTH-1:1]};
                default: shiftVal = {1'b0, work[WIDTH-1:1]};
            endcase
        end else begin
            if (mode == 2'b10) shiftVal = {work[WIDTH-2:0], work[WIDTH-1]};
            else               shiftVal = {work[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            work     <= '0;
            cnt      <= '0;
            dirRight <= 1'b0;
            mode     <= 2'b00;
            outReg   <= '0;
            zeroReg  <= 1'b0;
        end else if (accept) begin
            work     <= bus.IN;
            cnt      <= bus.ShiftAmt;
            dirRight <= bus.ShiftDir;
            mode     <= bus.ShiftMode;
            if (bus.ShiftAmt == '0) begin
                outReg  <= bus.IN;
                zeroReg <= (bus.IN == '0);
            end
        end else if (state == SHIFT) begin
            work <= shiftVal;
            cnt  <= cnt - AMT_W'(1);
            if (cnt == LAST_STEP) begin
                outReg  <= shiftVal;
                zeroReg <= (shiftVal == '0);
            end
        end
    end

`ifdef SEQ_SHIFT_CARRY_EN
    logic shiftCarry;
    logic carryReg;

    // Only the bit leaving on the final step is observable, so it loads straight into the flag.
    assign shiftCarry = dirRight ? work[0] : work[WIDTH-1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                 carryReg <= 1'b0;
        else if (accept && bus.ShiftAmt == '0)   carryReg <= 1'b0;
        else if (state == SHIFT && cnt == LAST_STEP) carryReg <= shiftCarry;
    end

    assign bus.Carry = carryReg;
`else
    assign bus.Carry = 1'b0;
`endif

    assign bus.Out  = outReg;
    assign bus.Zero = zeroReg;
    assign bus.Busy = (state == SHIFT);
    assign bus.Done = (state == DONE);
endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - directed self-checking bench for seq_shift_unit
module tb_seq_shift_unit;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef SEQ_SHIFT_CARRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    seq_shift_unit_if #(.WIDTH(8), .AMT_W(3)) bus ();

    seq_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setOp(input logic [7:0] inVal, input logic [2:0] amt,
                         input logic dir, input logic [1:0] mode);
        bus.Start     = 1'b1;
        bus.IN        = inVal;
        bus.ShiftAmt  = amt;
        bus.ShiftDir  = dir;
        bus.ShiftMode = mode;
    endtask

    task automatic runOp(input string tag, input logic [7:0] inVal, input logic [2:0] amt,
                         input logic dir, input logic [1:0] mode,
                         input logic [7:0] expOut, input logic expCarry, input logic expZero);
        setOp(inVal, amt, dir, mode);
        step();
        bus.Start = 1'b0;
        for (int c = 1; c <= int'(amt); c++) begin
            chk({tag, "_busy"}, {7'd0, bus.Busy}, 8'd1);
            chk({tag, "_nodone"}, {7'd0, bus.Done}, 8'd0);
            step();
        end
        chk({tag, "_done"}, {7'd0, bus.Done}, 8'd1);
        chk({tag, "_busylow"}, {7'd0, bus.Busy}, 8'd0);
        chk({tag, "_out"}, bus.Out, expOut);
        chk({tag, "_carry"}, {7'd0, bus.Carry}, {7'd0, expCarry & CARRY_EN});
        chk({tag, "_zero"}, {7'd0, bus.Zero}, {7'd0, expZero});
        step();
        chk({tag, "_donepulse"}, {7'd0, bus.Done}, 8'd0);
        chk({tag, "_outhold"}, bus.Out, expOut);
    endtask

    initial begin
        bus.Start = 1'b0; bus.IN = 8'h00; bus.ShiftAmt = 3'd0; bus.ShiftDir = 1'b0; bus.ShiftMode = 2'b00;
        step();
        step();
        chk("rst_out", bus.Out, 8'h00);
        chk("rst_busy", {7'd0, bus.Busy}, 8'd0);
        chk("rst_done", {7'd0, bus.Done}, 8'd0);
        chk("rst_carry", {7'd0, bus.Carry}, 8'd0);
        chk("rst_zero", {7'd0, bus.Zero}, 8'd0);
        Rst = 1'b0;
        step();

        runOp("asr3",  8'h96, 3'd3, 1'b1, 2'b01, 8'hF2, 1'b1, 1'b0);
        runOp("rol1",  8'h81, 3'd1, 1'b0, 2'b10, 8'h03, 1'b1, 1'b0);
        runOp("lsl7",  8'hFF, 3'd7, 1'b0, 2'b00, 8'h80, 1'b1, 1'b0);
        runOp("lsr1z", 8'h01, 3'd1, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1);
        runOp("amt0",  8'h5A, 3'd0, 1'b1, 2'b00, 8'h5A, 1'b0, 1'b0);
        runOp("res11", 8'hC3, 3'd2, 1'b1, 2'b11, 8'h30, 1'b1, 1'b0);

        // Handshake: ignored Start mid-shift, then back-to-back Start in the Done cycle.
        setOp(8'hF0, 3'd5, 1'b1, 2'b00);
        step();
        bus.Start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) setOp(8'h11, 3'd1, 1'b0, 2'b10);
            if (c == 3) bus.Start = 1'b0;
            chk("hs_busy", {7'd0, bus.Busy}, 8'd1);
            chk("hs_nodone", {7'd0, bus.Done}, 8'd0);
            step();
        end
        chk("hs_done", {7'd0, bus.Done}, 8'd1);
        chk("hs_out", bus.Out, 8'h07);
        chk("hs_carry", {7'd0, bus.Carry}, {7'd0, CARRY_EN});
        setOp(8'h01, 3'd2, 1'b1, 2'b10);
        step();
        bus.Start = 1'b0;
        chk("b2b_busy1", {7'd0, bus.Busy}, 8'd1);
        chk("b2b_nodone1", {7'd0, bus.Done}, 8'd0);
        step();
        chk("b2b_busy2", {7'd0, bus.Busy}, 8'd1);
        step();
        chk("b2b_done", {7'd0, bus.Done}, 8'd1);
        chk("b2b_out", bus.Out, 8'h40);
        chk("b2b_carry", {7'd0, bus.Carry}, 8'd0);
        step();
        chk("b2b_idle", {7'd0, bus.Done}, 8'd0);

        // Asynchronous reset in cycle 2 of a 7-shift operation.
        setOp(8'hFF, 3'd7, 1'b0, 2'b00);
        step();
        bus.Start = 1'b0;
        step();
        chk("ab_busy", {7'd0, bus.Busy}, 8'd1);
        Rst = 1'b1;
        #1;
        chk("ab_out", bus.Out, 8'h00);
        chk("ab_busy0", {7'd0, bus.Busy}, 8'd0);
        chk("ab_done0", {7'd0, bus.Done}, 8'd0);
        chk("ab_carry0", {7'd0, bus.Carry}, 8'd0);
        chk("ab_zero0", {7'd0, bus.Zero}, 8'd0);
        step();
        Rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("ab_nodone", {7'd0, bus.Done}, 8'd0);
            chk("ab_nobusy", {7'd0, bus.Busy}, 8'd0);
        end

        runOp("lsr7", 8'h80, 3'd7, 1'b1, 2'b00, 8'h01, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
